// File: rtl/mac_unit.sv
// ============================================================================
// Module   : mac_unit
// Brief    : Iterative shift-add multiply / multiply-accumulate execute unit
//            with a private accumulator and a one-cycle register-file write-back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [4:0]       rd_addr,
    output logic             busy,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data
);

    localparam int               c_CNT_W     = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MAC    = 2'b01;
    localparam logic [1:0] c_OP_MACCLR = 2'b10;
    localparam logic [1:0] c_OP_RDACC  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic                 w_accept;
    logic                 w_last;

    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_prod;
    logic [WIDTH-1:0]     r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [4:0]           r_rd;

    logic [WIDTH-1:0]     w_prod_n;
    logic [WIDTH-1:0]     w_acc_n;
    logic [WIDTH-1:0]     w_wb_data_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_state_n = (op == c_OP_RDACC) ? S_WB : S_MULT;
                end
            end
            S_MULT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_last    = 1'b1;
                    w_state_n = S_WB;
                end
            end
            S_WB:    w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // On the final MULT cycle w_prod_n already holds the complete product.
    assign w_prod_n = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_acc_n = r_acc;
        case (r_op)
            c_OP_MAC:    w_acc_n = r_acc + w_prod_n;
            c_OP_MACCLR: w_acc_n = w_prod_n;
            default:     w_acc_n = r_acc;
        endcase
    end

    assign w_wb_data_n = (r_op == c_OP_MUL) ? w_prod_n : w_acc_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= 2'b00;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rd     <= 5'd0;
            busy     <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= '0;
        end else begin
            busy  <= (w_state_n != S_IDLE);
            wb_we <= 1'b0;

            if (w_accept) begin
                r_op     <= op;
                r_mcand  <= rs1_val;
                r_mplier <= rs2_val;
                r_rd     <= rd_addr;
                r_prod   <= '0;
                r_cnt    <= '0;
                // RDACC skips MULT, so its write-back is issued straight from IDLE.
                if (op == c_OP_RDACC) begin
                    wb_we   <= (rd_addr != 5'd0);
                    wb_addr <= rd_addr;
                    wb_data <= r_acc;
                end
            end

            if (r_state == S_MULT) begin
                r_prod   <= w_prod_n;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_acc   <= w_acc_n;
                    r_cnt   <= '0;
                    wb_we   <= (r_rd != 5'd0);
                    wb_addr <= r_rd;
                    wb_data <= w_wb_data_n;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_unit.sv
// ============================================================================
// Module   : tb_mac_unit
// Brief    : Directed vector bench for mac_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_unit;

    localparam int c_W = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [c_W-1:0]   rs1_val;
    logic [c_W-1:0]   rs2_val;
    logic [4:0]       rd_addr;
    logic             busy;
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [c_W-1:0]   wb_data;

    int n_checks;
    int n_errors;

    mac_unit #(.WIDTH(c_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     op;
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic [4:0]     rd;
        logic [c_W-1:0] exp_data;
        int             exp_we;
        int             exp_busy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, then observe
    // busy and write-back activity until busy drops (bounded).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int busy_cyc, output int we_cyc,
                          output logic [31:0] d, output logic [4:0] ad);
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_addr = 5'($urandom);
        busy_cyc = 0; we_cyc = 0; d = '0; ad = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (wb_we) begin
                we_cyc++;
                d  = wb_data;
                ad = wb_addr;
            end
            if (!busy) break;
        end
    endtask

    initial begin
        int bc, wc, cnt;
        logic [31:0] d;
        logic [4:0]  ad;

        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{2'b00, 32'd7,        32'd6,        5'd5,  32'd42,       1, 33};
        vecs[1]  = '{2'b11, 32'd0,        32'd0,        5'd4,  32'd0,        1, 1};
        vecs[2]  = '{2'b10, 32'd3,        32'd4,        5'd10, 32'd12,       1, 33};
        vecs[3]  = '{2'b01, 32'd5,        32'd6,        5'd10, 32'd42,       1, 33};
        vecs[4]  = '{2'b11, 32'd0,        32'd0,        5'd10, 32'd42,       1, 1};
        vecs[5]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000001, 1, 33};
        vecs[6]  = '{2'b10, 32'hFFFFFFFF, 32'd1,        5'd8,  32'hFFFFFFFF, 1, 33};
        vecs[7]  = '{2'b01, 32'd1,        32'd1,        5'd8,  32'h00000000, 1, 33};
        vecs[8]  = '{2'b10, 32'd2,        32'd3,        5'd0,  32'd6,        0, 33};
        vecs[9]  = '{2'b11, 32'd0,        32'd0,        5'd1,  32'd6,        1, 1};
        vecs[10] = '{2'b00, 32'hFFFFFFFD, 32'd5,        5'd9,  32'hFFFFFFF1, 1, 33};
        vecs[11] = '{2'b01, 32'hFFFFFFFF, 32'd2,        5'd31, 32'd4,        1, 33};

        rst = 1'b0; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0; rd_addr = '0;
        #12;
        chk("reset_busy",    {31'd0, busy},  32'd0);
        chk("reset_wb_we",   {31'd0, wb_we}, 32'd0);
        chk("reset_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, bc, wc, d, ad);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
            chk($sformatf("v%0d_we_cycles", i), wc, vecs[i].exp_we);
            if (vecs[i].exp_we != 0) begin
                chk($sformatf("v%0d_wb_data", i), d, vecs[i].exp_data);
                chk($sformatf("v%0d_wb_addr", i), {27'd0, ad}, {27'd0, vecs[i].rd});
            end
        end

        // start pulsed mid-MULT must be dropped: exactly one write of 11*13
        @(negedge clk);
        op = 2'b00; rs1_val = 32'd11; rs2_val = 32'd13; rd_addr = 5'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        op = 2'b00; rs1_val = 32'd9; rs2_val = 32'd9; rd_addr = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; d = '0; ad = '0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (wb_we) begin
                cnt++;
                d  = wb_data;
                ad = wb_addr;
            end
        end
        chk("reject_we_count", cnt, 32'd1);
        chk("reject_wb_data", d, 32'd143);
        chk("reject_wb_addr", {27'd0, ad}, 32'd6);

        // asynchronous reset during the 10th MULT cycle of MAC 5*5 (acc was 4)
        @(negedge clk);
        op = 2'b01; rs1_val = 32'd5; rs2_val = 32'd5; rd_addr = 5'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        repeat (9) begin
            @(posedge clk);
            #1 if (wb_we) cnt++;
        end
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_busy",    {31'd0, busy},  32'd0);
        chk("rst_mid_wb_we",   {31'd0, wb_we}, 32'd0);
        chk("rst_mid_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_mid_wb_data", wb_data, 32'd0);
        chk("rst_mid_no_write", cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op(2'b11, 32'd0, 32'd0, 5'd2, bc, wc, d, ad);
        chk("post_rst_busy_cycles", bc, 32'd1);
        chk("post_rst_we_cycles", wc, 32'd1);
        chk("post_rst_acc", d, 32'd0);
        chk("post_rst_addr", {27'd0, ad}, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
